bus_arbiter_mux: RTL and testbench
==================================

# bus_arbiter_mux

Parametrised, registered successor to the datapath bus multiplexer. It selects one of `NSRC` `WIDTH`-bit sources onto the shared CPU bus using either fixed priority (legacy "highest index wins") or round-robin arbitration. The selected value is registered, and the block reports multi-driver conflicts with a saturating counter. It sits between the register file, special registers and immediate logic, and every bus consumer (ALU operand latches, MAR/MDR, PC).

## Interface
Parameters:
- `WIDTH`, 32, width of the bus and of each source.
- `NSRC`, 24, number of sources (R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C).
- `CNT_W`, 8, width of the conflict counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `clr`  in  1  reset. Synchronous and active-low: when `clr`=0 at a rising edge of `clk`, all state is reset.
- `rr_mode`  in  1  0 = fixed priority, 1 = round-robin.
- `hold`  in  1  freeze all arbitration state and outputs.
- `err_clr`  in  1  clear `conflict_cnt`.
- `src_req`  in  NSRC  per-source drive request (the legacy `Rxout`-style enables).
- `src_data`  in  NSRC*WIDTH  flattened sources; source i = `src_data[i*WIDTH +: WIDTH]`.
- `bus_out`  out  WIDTH  registered bus value.
- `bus_valid`  out  1  `bus_out` was loaded by a grant in the previous cycle.
- `grant`  out  NSRC  registered one-hot grant; all zero when there is no grant.
- `conflict`  out  1  registered; 1 when two or more requests were present in the previous cycle.
- `conflict_cnt`  out  CNT_W  saturating count of conflict cycles.

## Operation
- **Reset** (`clr`=0):
  - `bus_out`=0, `bus_valid`=0, `grant`=0, `conflict`=0, `conflict_cnt`=0.
  - Internal round-robin pointer `ptr` = NSRC-1, so the first round-robin search starts at source 0.
- **Fixed priority** (`rr_mode`=0): the highest-index requester wins. This matches the legacy last-enable-wins bus behaviour. `ptr` is not updated.
- **Round-robin** (`rr_mode`=1):
  - Search order is ptr+1, ptr+2, … with wrap-around modulo NSRC.
  - The first requester found wins, and `ptr` ← winner index.
  - With a single requester, that requester wins regardless of `ptr`.
- **Grant cycle** (any request, `hold`=0): `bus_out` ← winner's data, `grant` ← one-hot(winner), `bus_valid` ← 1.
- **No request** (`hold`=0): `bus_out` holds its last value, `grant`=0, `bus_valid`=0, `ptr` unchanged.
- **Conflict** (`hold`=0): `conflict` ← (popcount(`src_req`) ≥ 2).
  - `conflict_cnt` increments on each such cycle and saturates at 2^CNT_W−1.
- **`err_clr`**: `conflict_cnt` ← 0. If a conflict occurs in the same cycle, the clear wins and the result is 0.
- **`hold`=1**:
  - `bus_out`, `grant`, `bus_valid`, `conflict` and `ptr` keep their values.
  - `conflict_cnt` is not incremented. `err_clr` still acts.
- **Mode change**: takes effect on the next arbitration. Switching to round-robin keeps the current `ptr`.
- **Priority of controls**: `clr` > `hold` > normal operation.

## Timing
- Latency is 1 cycle: `src_req`/`src_data` sampled at edge N appear on `bus_out`/`grant` after edge N.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back grants are allowed every cycle. In round-robin, a source holding `src_req` continuously is served at least once every NSRC cycles.
- **Reset mid-operation**: outputs are 0 on the cycle after the `clr` edge. Requests present in that same cycle are ignored.
- The single-cycle combinational pick (NSRC-way search + WIDTH-bit mux) must close at the CPU clock target for the default parameters.

## Structure
- Shared package/include `bus_defs`:
  - Default `WIDTH`/`NSRC`.
  - Source index constants `SRC_R0`=0 … `SRC_R15`=15, `SRC_HI`=16, `SRC_LO`=17, `SRC_ZHI`=18, `SRC_ZLO`=19, `SRC_PC`=20, `SRC_MDR`=21, `SRC_INP`=22, `SRC_C`=23.
  - Mode constants `ARB_PRIO`=0, `ARB_RR`=1.
- Sub-module `rr_picker` (purely combinational):
  - Inputs: `src_req`, `ptr`, `rr_mode`.
  - Outputs: winner index, one-hot winner, `any_req`, `multi_req`.
- The top level holds the registers, data mux, pointer and counter.

## Test plan
- Reset, then `src_req`=bit 3 with R3 data 0xDEADBEEF → after 1 cycle: `bus_out`=0xDEADBEEF, `grant`=0x000008, `bus_valid`=1, `conflict`=0.
- Priority mode, `src_req` bits 5 and 21 with R5=0x11, MDR=0x22 → `bus_out`=0x22, `grant`=bit 21, `conflict`=1, `conflict_cnt`=1.
- Round-robin, bits 0, 4 and 23 held for 4 cycles after reset → grants in order 0, 4, 23, 0 (wrap), `conflict_cnt`=4.
- Request R7=0x5 for one cycle, then no request for 3 cycles → `bus_out` stays 0x5, `bus_valid`=0, `grant`=0.
- `CNT_W`=2 with 5 conflict cycles → `conflict_cnt` saturates at 3. `err_clr` together with a conflict → 0.
- `hold`=1 while requests change → all outputs frozen. `clr`=0 during `hold` → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/bus_arbiter_mux_pkg.sv
// Shared definitions for the CPU bus arbiter/multiplexer: default sizes,
// bus source indices and arbitration mode encoding.
package bus_arbiter_mux_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NSRC  = 24;
  localparam int DEF_CNT_W = 8;

  // Bus source indices (legacy Rxout enable order)
  localparam int SRC_R0  = 0;
  localparam int SRC_R15 = 15;
  localparam int SRC_HI  = 16;
  localparam int SRC_LO  = 17;
  localparam int SRC_ZHI = 18;
  localparam int SRC_ZLO = 19;
  localparam int SRC_PC  = 20;
  localparam int SRC_MDR = 21;
  localparam int SRC_INP = 22;
  localparam int SRC_C   = 23;

  typedef enum logic {
    ARB_PRIO = 1'b0,
    ARB_RR   = 1'b1
  } arbMode_e;

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Bus-side signal bundle of the arbiter: controls, requests, sources and
// the registered bus/status outputs. The arbiter uses the slave view.
interface bus_arbiter_mux_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 24,
  parameter int CNT_W = 8
);

  logic                    rr_mode;
  logic                    hold;
  logic                    err_clr;
  logic [NSRC-1:0]         src_req;
  logic [NSRC*WIDTH-1:0]   src_data;
  logic [WIDTH-1:0]        bus_out;
  logic                    bus_valid;
  logic [NSRC-1:0]         grant;
  logic                    conflict;
  logic [CNT_W-1:0]        conflict_cnt;

  modport master (
    output rr_mode, hold, err_clr, src_req, src_data,
    input  bus_out, bus_valid, grant, conflict, conflict_cnt
  );

  modport slave (
    input  rr_mode, hold, err_clr, src_req, src_data,
    output bus_out, bus_valid, grant, conflict, conflict_cnt
  );

endinterface

// File: rtl/bus_arbiter_mux_rr_picker.sv
// Combinational winner selection: highest index in priority mode, first
// requester after ptr (wrapping) in round-robin mode. Also flags whether
// any and whether more than one source is requesting.
module bus_arbiter_mux_rr_picker
  import bus_arbiter_mux_pkg::*;
#(
  parameter int NSRC  = DEF_NSRC,
  parameter int PTR_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  src_req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             rr_mode,
  output logic [PTR_W-1:0] winIdx,
  output logic [NSRC-1:0]  winOneHot,
  output logic             anyReq,
  output logic             multiReq
);

  localparam int POP_W = $clog2(NSRC + 1);

  arbMode_e   mode;
  logic [POP_W-1:0] reqCount;
  logic       found;
  int         cand;

  assign mode = arbMode_e'(rr_mode);

  // Pick the winning source and count requesters
  always_comb begin
    winIdx    = '0;
    winOneHot = '0;
    reqCount  = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_req[i]) begin
        reqCount = reqCount + POP_W'(1);
      end else begin
        reqCount = reqCount;
      end
    end
    case (mode)
      ARB_RR: begin
        // Search ptr+1, ptr+2, ... wrapping; first hit wins
        for (int i = 1; i <= NSRC; i++) begin
          cand = int'(ptr) + i;
          if (cand >= NSRC) begin
            cand = cand - NSRC;
          end else begin
            cand = cand;
          end
          if (!found && src_req[cand]) begin
            winIdx = PTR_W'(cand);
            found  = 1'b1;
          end else begin
            found  = found;
          end
        end
      end
      default: begin
        // Last enable wins, matching the legacy bus behaviour
        for (int i = 0; i < NSRC; i++) begin
          if (src_req[i]) begin
            winIdx = PTR_W'(i);
          end else begin
            winIdx = winIdx;
          end
        end
      end
    endcase
    anyReq   = |src_req;
    multiReq = (reqCount >= POP_W'(2));
    if (anyReq) begin
      winOneHot[winIdx] = 1'b1;
    end else begin
      winOneHot = '0;
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered CPU bus arbiter/multiplexer. Selects one of NSRC sources by
// fixed priority or round-robin, registers the bus value and grant, and
// keeps a saturating count of multi-driver cycles.
module bus_arbiter_mux
  import bus_arbiter_mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSRC  = DEF_NSRC,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic              clk,
  input logic              clr,
  bus_arbiter_mux_if.slave bif
);

  localparam int PTR_W = $clog2(NSRC);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PTR_W-1:0] ptrR;
  logic [WIDTH-1:0] busOutR;
  logic             busValidR;
  logic [NSRC-1:0]  grantR;
  logic             conflictR;
  logic [CNT_W-1:0] conflictCntR;

  logic [PTR_W-1:0] winIdxS;
  logic [NSRC-1:0]  winOneHotS;
  logic             anyReqS;
  logic             multiReqS;
  logic [WIDTH-1:0] winDataS;

  bus_arbiter_mux_rr_picker #(
    .NSRC  (NSRC),
    .PTR_W (PTR_W)
  ) uPicker (
    .src_req   (bif.src_req),
    .ptr       (ptrR),
    .rr_mode   (bif.rr_mode),
    .winIdx    (winIdxS),
    .winOneHot (winOneHotS),
    .anyReq    (anyReqS),
    .multiReq  (multiReqS)
  );

  assign winDataS = bif.src_data[int'(winIdxS)*WIDTH +: WIDTH];

  // Bus, grant, pointer and conflict state; clr beats hold beats arbitration
  always_ff @(posedge clk) begin
    if (!clr) begin
      ptrR         <= PTR_W'(NSRC - 1);
      busOutR      <= '0;
      busValidR    <= 1'b0;
      grantR       <= '0;
      conflictR    <= 1'b0;
      conflictCntR <= '0;
    end else begin
      // err_clr acts even while held and beats a same-cycle conflict
      if (bif.err_clr) begin
        conflictCntR <= '0;
      end else if (!bif.hold && multiReqS && (conflictCntR != CNT_MAX)) begin
        conflictCntR <= conflictCntR + CNT_W'(1);
      end else begin
        conflictCntR <= conflictCntR;
      end

      if (!bif.hold) begin
        conflictR <= multiReqS;
        if (anyReqS) begin
          busOutR   <= winDataS;
          grantR    <= winOneHotS;
          busValidR <= 1'b1;
          if (arbMode_e'(bif.rr_mode) == ARB_RR) begin
            ptrR <= winIdxS;
          end else begin
            ptrR <= ptrR;
          end
        end else begin
          busOutR   <= busOutR;
          grantR    <= '0;
          busValidR <= 1'b0;
          ptrR      <= ptrR;
        end
      end else begin
        ptrR      <= ptrR;
        busOutR   <= busOutR;
        busValidR <= busValidR;
        grantR    <= grantR;
        conflictR <= conflictR;
      end
    end
  end

  assign bif.bus_out      = busOutR;
  assign bif.bus_valid    = busValidR;
  assign bif.grant        = grantR;
  assign bif.conflict     = conflictR;
  assign bif.conflict_cnt = conflictCntR;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux: default instance plus a CNT_W=2
// instance for counter saturation.
module tb_bus_arbiter_mux;
  import bus_arbiter_mux_pkg::*;

  localparam int W = 32;
  localparam int N = 24;

  logic clk;
  logic clrA;
  logic clrB;
  int   compCnt;
  int   misCnt;

  bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N), .CNT_W(8)) bifA ();
  bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N), .CNT_W(2)) bifB ();

  bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .CNT_W(8)) dutA (
    .clk (clk),
    .clr (clrA),
    .bif (bifA.slave)
  );

  bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .CNT_W(2)) dutB (
    .clk (clk),
    .clr (clrB),
    .bif (bifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compCnt++;
    assert (obs === exp) else begin
      misCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSrc(input int idx, input logic [W-1:0] v);
    bifA.src_data[idx*W +: W] = v;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_bus"},   64'(bifA.bus_out),      64'h0);
    chk({tag, "_valid"}, 64'(bifA.bus_valid),    64'h0);
    chk({tag, "_grant"}, 64'(bifA.grant),        64'h0);
    chk({tag, "_conf"},  64'(bifA.conflict),     64'h0);
    chk({tag, "_cnt"},   64'(bifA.conflict_cnt), 64'h0);
  endtask

  initial begin
    int rrOrder [4];
    logic [W-1:0] rrData [4];
    rrOrder = '{0, 4, 23, 0};
    rrData  = '{32'hA0, 32'hA4, 32'hA23, 32'hA0};
    compCnt = 0;
    misCnt  = 0;
    clrA = 1'b0;
    clrB = 1'b0;
    bifA.rr_mode = 1'b0; bifA.hold = 1'b0; bifA.err_clr = 1'b0;
    bifA.src_req = '0;   bifA.src_data = '0;
    bifB.rr_mode = 1'b0; bifB.hold = 1'b0; bifB.err_clr = 1'b0;
    bifB.src_req = '0;   bifB.src_data = '0;

    // Reset state
    tick();
    chkAllZero("reset");
    chk("resetB_cnt", 64'(bifB.conflict_cnt), 64'h0);

    // Single request R3
    clrA = 1'b1; clrB = 1'b1;
    setSrc(SRC_R0 + 3, 32'hDEADBEEF);
    bifA.src_req = 24'h000008;
    tick();
    chk("r3_bus",   64'(bifA.bus_out),   64'hDEADBEEF);
    chk("r3_grant", 64'(bifA.grant),     64'h000008);
    chk("r3_valid", 64'(bifA.bus_valid), 64'h1);
    chk("r3_conf",  64'(bifA.conflict),  64'h0);

    // Priority: R5 vs MDR, highest index wins
    setSrc(5, 32'h11);
    setSrc(SRC_MDR, 32'h22);
    bifA.src_req = (24'h1 << 5) | (24'h1 << SRC_MDR);
    tick();
    chk("prio_bus",   64'(bifA.bus_out),      64'h22);
    chk("prio_grant", 64'(bifA.grant),        64'h200000);
    chk("prio_conf",  64'(bifA.conflict),     64'h1);
    chk("prio_cnt",   64'(bifA.conflict_cnt), 64'h1);

    // Round-robin from reset: 0, 4, 23, 0
    clrA = 1'b0; bifA.src_req = '0;
    tick();
    clrA = 1'b1;
    bifA.rr_mode = 1'b1;
    setSrc(0, 32'hA0); setSrc(4, 32'hA4); setSrc(SRC_C, 32'hA23);
    bifA.src_req = (24'h1 << 0) | (24'h1 << 4) | (24'h1 << SRC_C);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_grant", 64'(bifA.grant),   64'(24'h1 << rrOrder[k]));
      chk("rr_bus",   64'(bifA.bus_out), 64'(rrData[k]));
    end
    chk("rr_cnt", 64'(bifA.conflict_cnt), 64'h4);

    // One R7 request, then idle: bus holds, valid/grant drop
    bifA.rr_mode = 1'b0;
    setSrc(7, 32'h5);
    bifA.src_req = 24'h1 << 7;
    tick();
    chk("r7_bus",   64'(bifA.bus_out),   64'h5);
    chk("r7_valid", 64'(bifA.bus_valid), 64'h1);
    bifA.src_req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_bus",   64'(bifA.bus_out),   64'h5);
      chk("idle_valid", 64'(bifA.bus_valid), 64'h0);
      chk("idle_grant", 64'(bifA.grant),     64'h0);
      chk("idle_conf",  64'(bifA.conflict),  64'h0);
    end
    chk("idle_cnt", 64'(bifA.conflict_cnt), 64'h4);

    // Hold freezes everything; err_clr still clears; clr beats hold
    setSrc(2, 32'h222); setSrc(9, 32'h999);
    bifA.src_req = (24'h1 << 2) | (24'h1 << 9);
    tick();
    chk("prehold_bus", 64'(bifA.bus_out),      64'h999);
    chk("prehold_cnt", 64'(bifA.conflict_cnt), 64'h5);
    bifA.hold = 1'b1;
    bifA.src_req = 24'h1 << 3;
    tick();
    chk("hold_bus",   64'(bifA.bus_out),      64'h999);
    chk("hold_grant", 64'(bifA.grant),        64'h200);
    chk("hold_valid", 64'(bifA.bus_valid),    64'h1);
    chk("hold_conf",  64'(bifA.conflict),     64'h1);
    chk("hold_cnt",   64'(bifA.conflict_cnt), 64'h5);
    bifA.err_clr = 1'b1;
    bifA.src_req = (24'h1 << 1) | (24'h1 << 2);
    tick();
    chk("holdclr_cnt",   64'(bifA.conflict_cnt), 64'h0);
    chk("holdclr_bus",   64'(bifA.bus_out),      64'h999);
    chk("holdclr_grant", 64'(bifA.grant),        64'h200);
    bifA.err_clr = 1'b0;
    clrA = 1'b0;
    tick();
    chkAllZero("holdrst");
    clrA = 1'b1;
    bifA.hold = 1'b0;

    // Round-robin single requester wins regardless of ptr
    bifA.rr_mode = 1'b1;
    setSrc(10, 32'hAA);
    bifA.src_req = 24'h1 << 10;
    tick();
    chk("rr1_grant", 64'(bifA.grant),   64'h400);
    chk("rr1_bus",   64'(bifA.bus_out), 64'hAA);
    bifA.src_req = 24'h1 << 5;
    tick();
    chk("rr2_grant", 64'(bifA.grant),   64'h20);
    chk("rr2_bus",   64'(bifA.bus_out), 64'h11);

    // Priority does not move ptr (5); back in RR, search from 6 finds 6
    bifA.rr_mode = 1'b0;
    setSrc(6, 32'h66);
    bifA.src_req = (24'h1 << 3) | (24'h1 << 6);
    tick();
    chk("mode_prio_grant", 64'(bifA.grant),   64'h40);
    chk("mode_prio_bus",   64'(bifA.bus_out), 64'h66);
    bifA.rr_mode = 1'b1;
    tick();
    chk("mode_rr_grant", 64'(bifA.grant),        64'h40);
    chk("mode_rr_conf",  64'(bifA.conflict),     64'h1);
    chk("mode_rr_cnt",   64'(bifA.conflict_cnt), 64'h2);

    // Reset mid-operation ignores concurrent requests
    clrA = 1'b0;
    bifA.src_req = 24'h1 << 1;
    tick();
    chkAllZero("midrst");

    // CNT_W=2 saturation and err_clr priority over conflict
    bifB.src_req = 24'h3;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sat_cnt", 64'(bifB.conflict_cnt), 64'((k > 3) ? 3 : k));
    end
    bifB.err_clr = 1'b1;
    tick();
    chk("errclr_cnt", 64'(bifB.conflict_cnt), 64'h0);
    bifB.err_clr = 1'b0;
    tick();
    chk("after_errclr_cnt", 64'(bifB.conflict_cnt), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, misCnt);
    $finish;
  end

endmodule
